// File: rtl/period_enb_pkg.sv
// Shared types and elaboration helpers for the multi-channel period enable generator.
package period_enb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // Clocks per base tick; callers guarantee an integer result >= 1.
    function automatic int prescale_count(input int clkfreq_mhz, input int tick_ns);
        return (tick_ns * clkfreq_mhz) / 1000;
    endfunction

    function automatic int ch_idx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/period_enb_chan.sv
// One enable channel: IDLE/RUN control, prescaler, tick counter and active/pending period.
module period_enb_chan
    import period_enb_pkg::*;
#(
    parameter int PW       = 16,
    parameter int PRESCALE = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ld,
    input  logic [PW-1:0] ld_period,
    input  logic          ld_oneshot,
    input  logic          start,
    input  logic          stop,
    output logic          enb_out,
    output logic          busy
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    chan_state_t    state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PW-1:0]  tick_q, tick_d;
    logic [PW-1:0]  per_q, per_d;
    logic           os_q, os_d;
    logic [PW-1:0]  pend_per_q, pend_per_d;
    logic           pend_os_q, pend_os_d;
    logic           pend_vld_q, pend_vld_d;
    logic           pulse_q, pulse_d;
    logic           fin_q, fin_d;

    logic [PW-1:0]  eff_per;
    logic           eff_os;
    logic           eff_vld;
    logic [PW-1:0]  start_per;
    logic           start_os;
    logic           terminal;

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        tick_d     = tick_q;
        per_d      = per_q;
        os_d       = os_q;
        pend_per_d = pend_per_q;
        pend_os_d  = pend_os_q;
        pend_vld_d = pend_vld_q;
        pulse_d    = 1'b0;
        fin_d      = 1'b0;

        // A load on this very edge is the freshest value and takes priority over stored pending.
        eff_per   = ld ? ld_period  : pend_per_q;
        eff_os    = ld ? ld_oneshot : pend_os_q;
        eff_vld   = ld | pend_vld_q;
        start_per = eff_vld ? eff_per : per_q;
        start_os  = eff_vld ? eff_os  : os_q;
        terminal  = (state_q == RUN) && (pre_q == PRE_MAX) && (tick_q == per_q - PW'(1));

        if (ld) begin
            if (state_q == IDLE) begin
                per_d      = ld_period;
                os_d       = ld_oneshot;
                pend_vld_d = 1'b0;
            end else begin
                pend_per_d = ld_period;
                pend_os_d  = ld_oneshot;
                pend_vld_d = 1'b1;
            end
        end

        if (clr || stop) begin
            state_d = IDLE;
            pre_d   = '0;
            tick_d  = '0;
        end else if (start) begin
            per_d      = start_per;
            os_d       = start_os;
            pend_vld_d = 1'b0;
            pre_d      = '0;
            tick_d     = '0;
            state_d    = (start_per != '0) ? RUN : IDLE;
        end else if (state_q == RUN) begin
            if (fin_q) begin
                state_d = IDLE;
                pre_d   = '0;
                tick_d  = '0;
            end else if (terminal) begin
                pulse_d = 1'b1;
                pre_d   = '0;
                tick_d  = '0;
                if (eff_vld) begin
                    per_d      = eff_per;
                    os_d       = eff_os;
                    pend_vld_d = 1'b0;
                end
                // Leave RUN one cycle later so busy stays high through the final pulse.
                fin_d = os_q | (eff_vld & (eff_per == '0));
            end else if (pre_q == PRE_MAX) begin
                pre_d  = '0;
                tick_d = tick_q + PW'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            tick_q     <= '0;
            per_q      <= '0;
            os_q       <= 1'b0;
            pend_per_q <= '0;
            pend_os_q  <= 1'b0;
            pend_vld_q <= 1'b0;
            pulse_q    <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            per_q      <= per_d;
            os_q       <= os_d;
            pend_per_q <= pend_per_d;
            pend_os_q  <= pend_os_d;
            pend_vld_q <= pend_vld_d;
            pulse_q    <= pulse_d;
            fin_q      <= fin_d;
        end
    end

    assign enb_out = pulse_q;
    assign busy    = (state_q == RUN);

endmodule

// File: rtl/period_enb_multi.sv
// NCH independent runtime-programmable enable generators sharing one load port.
module period_enb_multi
    import period_enb_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int PW          = 16,
    parameter int CLKFREQ_MHZ = 100,
    parameter int TICK_NS     = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       ld,
    input  logic [ch_idx_w(NCH)-1:0]   ld_ch,
    input  logic [PW-1:0]              ld_period,
    input  logic                       ld_oneshot,
    input  logic [NCH-1:0]             start,
    input  logic [NCH-1:0]             stop,
    output logic [NCH-1:0]             enb_out,
    output logic [NCH-1:0]             busy
);

    localparam int CH_IDX_W = ch_idx_w(NCH);
    localparam int PRESCALE = prescale_count(CLKFREQ_MHZ, TICK_NS);

    logic [NCH-1:0] ld_hit;

    // Indices at or beyond NCH match no channel, so such loads fall away.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign ld_hit[gi] = ld && (ld_ch == CH_IDX_W'(gi));

            period_enb_chan #(
                .PW       (PW),
                .PRESCALE (PRESCALE)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .clr        (clr),
                .ld         (ld_hit[gi]),
                .ld_period  (ld_period),
                .ld_oneshot (ld_oneshot),
                .start      (start[gi]),
                .stop       (stop[gi]),
                .enb_out    (enb_out[gi]),
                .busy       (busy[gi])
            );
        end
    endgenerate

endmodule
